// File: rtl/float_to_int.sv
// Multi-cycle IEEE-754 single-precision to signed 32-bit integer converter.
// Rounds toward zero; NaN, infinities and out-of-range operands saturate and raise ofw.
module float_to_int (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] op_a,
  input  logic        in_valid,
  output logic        busy,
  output logic [31:0] out_z,
  output logic        ofw,
  output logic        out_valid
);

  typedef enum logic [2:0] {IDLE, CLASSIFY, SHIFT, NEGATE, OUTPUT} state_t;

  state_t      state_q;
  logic [31:0] op_q;
  logic [31:0] mag_q;
  logic [4:0]  k_q;
  logic        left_q;
  logic [31:0] res_q;
  logic        res_ofw_q;
  logic [31:0] out_z_q;
  logic        ofw_q;
  logic        out_valid_q;
  logic        busy_q;

  logic        sgn;
  logic [7:0]  expo;
  logic [22:0] man;
  logic        is_nan;
  logic        is_pos_ovf;
  logic        is_min_int;
  logic        is_neg_ovf;
  logic        is_small;
  logic        shift_left;
  logic [4:0]  k_init;

  assign sgn  = op_q[31];
  assign expo = op_q[30:23];
  assign man  = op_q[22:0];

  assign is_nan     = (expo == 8'hFF) && (man != 23'd0);
  assign is_pos_ovf = !sgn && (expo >= 8'd158);
  assign is_min_int = (op_q == 32'hCF00_0000);
  assign is_neg_ovf = sgn && (expo >= 8'd158);
  assign is_small   = (expo < 8'd127);
  // The integer point sits 150 exponent steps above the mantissa LSB.
  assign shift_left = (expo >= 8'd150);
  assign k_init     = shift_left ? 5'(expo - 8'd150) : 5'(8'd150 - expo);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      op_q        <= 32'd0;
      mag_q       <= 32'd0;
      k_q         <= 5'd0;
      left_q      <= 1'b0;
      res_q       <= 32'd0;
      res_ofw_q   <= 1'b0;
      out_z_q     <= 32'd0;
      ofw_q       <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_q    <= op_a;
            busy_q  <= 1'b1;
            state_q <= CLASSIFY;
          end
        end
        CLASSIFY: begin
          mag_q     <= {8'b0, 1'b1, man};
          k_q       <= k_init;
          left_q    <= shift_left;
          res_ofw_q <= 1'b0;
          if (is_nan) begin
            res_q     <= 32'h8000_0000;
            res_ofw_q <= 1'b1;
            state_q   <= OUTPUT;
          end else if (is_pos_ovf) begin
            res_q     <= 32'h7FFF_FFFF;
            res_ofw_q <= 1'b1;
            state_q   <= OUTPUT;
          end else if (is_min_int) begin
            res_q   <= 32'h8000_0000;
            state_q <= OUTPUT;
          end else if (is_neg_ovf) begin
            res_q     <= 32'h8000_0000;
            res_ofw_q <= 1'b1;
            state_q   <= OUTPUT;
          end else if (is_small) begin
            res_q   <= 32'd0;
            state_q <= OUTPUT;
          end else if (k_init == 5'd0) begin
            state_q <= NEGATE;
          end else begin
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          mag_q <= left_q ? (mag_q << 1) : (mag_q >> 1);
          k_q   <= k_q - 5'd1;
          // Leave as the counter reaches zero so a k-bit shift costs exactly k cycles.
          if (k_q == 5'd1) begin
            state_q <= NEGATE;
          end
        end
        NEGATE: begin
          res_q     <= sgn ? (~mag_q + 32'd1) : mag_q;
          res_ofw_q <= 1'b0;
          state_q   <= OUTPUT;
        end
        OUTPUT: begin
          out_z_q     <= res_q;
          ofw_q       <= res_ofw_q;
          out_valid_q <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign out_z     = out_z_q;
  assign ofw       = ofw_q;
  assign out_valid = out_valid_q;

endmodule
